// File: rtl/cp_serial_sub_nb.sv
// cp_serial_sub_nb: bit-serial subtractor, d = a - b - bin, one bit per clock, LSB first.
// A single borrow flip-flop ripples through WIDTH clocks; the operands are captured on start
// and the result is held until the next accepted start.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    synchronous active-high reset (dominates every other input)
//   i_start  start request, accepted in IDLE or DONE, ignored in RUN
//   i_a      minuend, sampled on the accepting edge
//   i_b      subtrahend, sampled on the accepting edge
//   i_bin    borrow-in, sampled on the accepting edge
//   o_busy   high while the serial subtract is running
//   o_done   one-cycle pulse when o_d/o_bout/o_ovf become valid
//   o_d      difference, modulo 2^WIDTH
//   o_bout   borrow-out (a < b + bin, unsigned)
//   o_ovf    signed overflow of the difference
//
// Build option: define CP_SUB_OVF_EN to generate the signed overflow flag; when it is
// undefined, o_ovf is tied low and no MSB capture logic exists.

module cp_serial_sub_nb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_d,
  output logic             o_bout,
  output logic             o_ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CntW-1:0]  cnt_q;

  logic a0;
  logic b0;
  logic d_bit;
  logic br_next;
  logic accept;
  logic last;

  // One full-subtractor slice working on the current LSBs.
  always_comb begin
    a0      = sa_q[0];
    b0      = sb_q[0];
    d_bit   = a0 ^ b0 ^ br_q;
    br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  end

  assign accept = i_start && (state_q != StRun);
  assign last   = (cnt_q == CntW'(WIDTH - 1));
  assign o_busy = (state_q == StRun);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      o_done  <= 1'b0;
      o_d     <= '0;
      o_bout  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            state_q <= StRun;
            sa_q    <= i_a;
            sb_q    <= i_b;
            br_q    <= i_bin;
            res_q   <= '0;
            cnt_q   <= '0;
            o_d     <= '0;
            o_bout  <= 1'b0;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          br_q  <= br_next;
          res_q <= {d_bit, res_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CntW'(1);
          if (last) begin
            // The last difference bit lands at the MSB as the result is published.
            state_q <= StDone;
            o_done  <= 1'b1;
            o_bout  <= br_next;
            o_d     <= {d_bit, res_q[WIDTH-1:1]};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CP_SUB_OVF_EN
  logic a_msb_q;
  logic b_msb_q;

  // Overflow only when operand signs differ and the result sign departs from the minuend.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= i_a[WIDTH-1];
      b_msb_q <= i_b[WIDTH-1];
      o_ovf   <= 1'b0;
    end else if ((state_q == StRun) && last) begin
      o_ovf <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
    end
  end
`else
  assign o_ovf = 1'b0;
`endif

endmodule
